data_mem_responder: RTL and testbench

- Multi-cycle data-memory responder: the memory-side end of the pipeline's MEM-stage load/store interface (MemRead/MemWrite/address/write-data from EX_MEM).
- Replaces the single-cycle data memory in the pipelined CPU.
- Accepts one word request at a time and holds the pipeline with stall_o for a fixed latency.
- Returns read data and a one-cycle completion pulse, ack_o.

---
 rtl/dmem_pkg.sv | 17 +
 rtl/data_mem_responder_if.sv | 23 ++
 rtl/dmem_array.sv | 29 ++
 rtl/data_mem_responder.sv | 150 +++++++++++++++
 tb/tb_data_mem_responder.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        COMMIT,
        DONE
    } state_e;

    localparam int unsigned WORD_BYTES = 4;

    function automatic int unsigned cnt_width(input int unsigned lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// MEM-stage load/store bus between the pipeline and the data-memory responder.
interface data_mem_responder_if;

    logic [31:0] addr_i;
    logic        MemRead_i;
    logic        MemWrite_i;
    logic [31:0] data_i;
    logic [31:0] data_o;
    logic        stall_o;
    logic        ack_o;
    logic        err_o;

    modport master (
        output addr_i, MemRead_i, MemWrite_i, data_i,
        input  data_o, stall_o, ack_o, err_o
    );

    modport slave (
        input  addr_i, MemRead_i, MemWrite_i, data_i,
        output data_o, stall_o, ack_o, err_o
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port word storage: synchronous write and registered synchronous read.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int DATA_W      = 32,
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic              re_i,
    input  logic [IW-1:0]     idx_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[idx_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: stalls the pipeline for LATENCY cycles per access.
module data_mem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 4,
    parameter int DATA_W      = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    data_mem_responder_if.slave  bus
);

    localparam int CW = cnt_width(LATENCY);
    localparam int AW = $clog2(WORD_BYTES);
    localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
    localparam bit FAST = (LATENCY == 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              err_q, err_d;
    logic              zero_q, zero_d;

    logic              req;
    logic              stall;
    logic [31:0]       a_s;
    logic [DATA_W-1:0] wd_s;
    logic              rd_s, wr_s, err_s;
    logic              do_acc, we, re;
    logic [DATA_W-1:0] rdata;

    function automatic logic bad_req(
        input logic [31:0] a,
        input logic        rd,
        input logic        wr
    );
        return (a[AW-1:0] != '0) || ((a >> AW) >= DEPTH_L) || (rd && wr);
    endfunction

    assign req = bus.MemRead_i | bus.MemWrite_i;

    // With LATENCY=1 the IDLE cycle itself is the commit cycle.
    assign a_s    = FAST ? bus.addr_i     : addr_q;
    assign wd_s   = FAST ? bus.data_i     : wdata_q;
    assign rd_s   = FAST ? bus.MemRead_i  : rd_q;
    assign wr_s   = FAST ? bus.MemWrite_i : wr_q;
    assign err_s  = bad_req(a_s, rd_s, wr_s);
    assign do_acc = FAST ? (state_q == IDLE) && req
                         : (state_q == COMMIT);
    assign we     = do_acc && wr_s && !err_s && !rst_i;
    assign re     = do_acc && rd_s && !err_s && !rst_i;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        err_d   = err_q;
        zero_d  = zero_q;
        stall   = 1'b0;
        if (do_acc && rd_s) begin
            zero_d = err_s;
        end
        unique case (state_q)
            IDLE: begin
                stall = req;
                if (req) begin
                    addr_d  = bus.addr_i;
                    wdata_d = bus.data_i;
                    rd_d    = bus.MemRead_i;
                    wr_d    = bus.MemWrite_i;
                    err_d   = bad_req(bus.addr_i, bus.MemRead_i,
                                      bus.MemWrite_i);
                    cnt_d   = CW'(LATENCY - 1);
                    if (FAST) begin
                        state_d = DONE;
                    end else if (LATENCY == 2) begin
                        state_d = COMMIT;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q - CW'(1);
                if (cnt_d == CW'(1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                stall   = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            err_q   <= 1'b0;
            zero_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            err_q   <= err_d;
            zero_q  <= zero_d;
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .DATA_W      (DATA_W)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (we),
        .re_i    (re),
        .idx_i   (a_s[AW +: IW]),
        .wdata_i (wd_s),
        .rdata_o (rdata)
    );

    assign bus.stall_o = stall;
    assign bus.ack_o   = (state_q == DONE);
    assign bus.err_o   = (state_q == DONE) && err_q;
    assign bus.data_o  = zero_q ? '0 : rdata;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder at LATENCY=4 and LATENCY=1.
module tb_data_mem_responder;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   a1, a2;

    data_mem_responder_if b4 ();
    data_mem_responder_if b1 ();

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(4), .DATA_W(32)) u4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b4)
    );

    data_mem_responder #(.DEPTH_WORDS(256), .LATENCY(1), .DATA_W(32)) u1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit s, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] d);
        if (s) begin
            b1.MemRead_i = rd; b1.MemWrite_i = wr;
            b1.addr_i = a; b1.data_i = d;
        end else begin
            b4.MemRead_i = rd; b4.MemWrite_i = wr;
            b4.addr_i = a; b4.data_i = d;
        end
    endtask

    function automatic logic st(input bit s);
        return s ? b1.stall_o : b4.stall_o;
    endfunction

    function automatic logic ak(input bit s);
        return s ? b1.ack_o : b4.ack_o;
    endfunction

    function automatic logic er(input bit s);
        return s ? b1.err_o : b4.err_o;
    endfunction

    function automatic logic [31:0] dat(input bit s);
        return s ? b1.data_o : b4.data_o;
    endfunction

    // Issues one request in the current cycle and checks the full latency.
    task automatic xfer(input bit s, input int lat, input logic rd,
                        input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic exp_err,
                        input bit chk_d, input logic [31:0] exp_d,
                        output int ack_cyc);
        drive(s, rd, wr, a, d);
        for (int c = 0; c < lat; c++) begin
            #1;
            check("stall_busy", 32'(st(s)), 32'd1);
            check("ack_early", 32'(ak(s)), 32'd0);
            tick();
        end
        #1;
        check("ack_done", 32'(ak(s)), 32'd1);
        check("err_done", 32'(er(s)), 32'(exp_err));
        check("stall_done", 32'(st(s)), 32'd0);
        if (chk_d) check("data_done", dat(s), exp_d);
        ack_cyc = cyc;
        tick();
        drive(s, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        tick(); tick();
        rst = 1'b0;
        tick();
        #1;
        check("rst_stall", 32'(b4.stall_o), 32'd0);
        check("rst_ack", 32'(b4.ack_o), 32'd0);
        check("rst_err", 32'(b4.err_o), 32'd0);
        check("rst_data", b4.data_o, 32'h0);
        check("rst_data1", b1.data_o, 32'h0);
        tick();

        // Test 1: basic store then load, LATENCY=4
        xfer(0, 4, 0, 1, 32'h10, 32'hDEADBEEF, 0, 1, 32'h0, a1);
        xfer(0, 4, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, a1);

        // Test 2: LATENCY=1
        xfer(1, 1, 0, 1, 32'h0, 32'h12345678, 0, 0, 32'h0, a1);
        xfer(1, 1, 1, 0, 32'h0, 32'h0, 0, 1, 32'h12345678, a1);
        #1;
        check("l1_idle_stall", 32'(b1.stall_o), 32'd0);
        tick();

        // Test 3: back-to-back store/load
        xfer(0, 4, 0, 1, 32'h20, 32'h55AA33CC, 0, 0, 32'h0, a1);
        xfer(0, 4, 1, 0, 32'h20, 32'h0, 0, 1, 32'h55AA33CC, a2);
        check("b2b_spacing", 32'(a2 - a1), 32'd5);
        #1;
        check("b2b_no_reaccept", 32'(b4.stall_o), 32'd0);
        tick();
        #1;
        check("b2b_no_ack", 32'(b4.ack_o), 32'd0);
        tick();

        // Test 4: error cases
        xfer(0, 4, 0, 1, 32'h13, 32'hBAD0BAD0, 1, 0, 32'h0, a1);
        xfer(0, 4, 0, 1, 32'h400, 32'hBAD1BAD1, 1, 0, 32'h0, a1);
        xfer(0, 4, 1, 1, 32'h10, 32'h0BADF00D, 1, 1, 32'h0, a1);
        xfer(0, 4, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, a1);
        xfer(0, 4, 1, 0, 32'h11, 32'h0, 1, 1, 32'h0, a1);
        xfer(0, 4, 0, 1, 32'h3FC, 32'hA5A5F00F, 0, 0, 32'h0, a1);
        xfer(0, 4, 1, 0, 32'h3FC, 32'h0, 0, 1, 32'hA5A5F00F, a1);
        xfer(0, 4, 1, 0, 32'h10, 32'h0, 0, 1, 32'hDEADBEEF, a1);

        // Test 5: reset cancels an in-flight store
        xfer(0, 4, 0, 1, 32'h24, 32'h11112222, 0, 0, 32'h0, a1);
        drive(0, 0, 1, 32'h24, 32'hCAFEF00D);
        #1;
        check("rst5_stall_T", 32'(b4.stall_o), 32'd1);
        tick();
        #1;
        check("rst5_stall_T1", 32'(b4.stall_o), 32'd1);
        tick();
        rst = 1'b1;
        drive(0, 0, 0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check("rst5_stall", 32'(b4.stall_o), 32'd0);
            check("rst5_ack", 32'(b4.ack_o), 32'd0);
            if (c == 0) check("rst5_data", b4.data_o, 32'h0);
            tick();
        end
        xfer(0, 4, 1, 0, 32'h24, 32'h0, 0, 1, 32'h11112222, a1);

        // Test 6: long idle
        for (int c = 0; c < 20; c++) begin
            #1;
            check("idle_stall", 32'(b4.stall_o), 32'd0);
            check("idle_ack", 32'(b4.ack_o), 32'd0);
            check("idle_data", b4.data_o, 32'h11112222);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
